// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the two-port APB arbiter in front of the SDRAM APB slave.
//   arb_state_t : downstream transfer phase (idle, APB setup, APB access)
//   PRIO_RR     : round-robin arbitration between m0 and m1
//   PRIO_FIXED  : fixed priority, m0 always wins a tie
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2
    } arb_state_t;

    localparam int unsigned PRIO_RR    = 0;
    localparam int unsigned PRIO_FIXED = 1;

    // One-hot grant codes; bit N is port mN.
    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way arbiter.
//   req   : request vector, bit N is port mN
//   last  : port granted most recently (0 = m0, 1 = m1)
//   mode  : 0 = round-robin, 1 = fixed priority with m0 highest
//   grant : one-hot grant, all zero when nothing is requested
module rr_arb2
    import sdram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       mode,
    output logic [1:0] grant
);

    always_comb begin
        grant = GRANT_NONE;
        unique case (req)
            2'b01: grant = GRANT_M0;
            2'b10: grant = GRANT_M1;
            2'b11: begin
                if (mode) begin
                    grant = GRANT_M0;
                end else begin
                    // On a tie the port that was not served last goes next.
                    grant = last ? GRANT_M0 : GRANT_M1;
                end
            end
            default: grant = GRANT_NONE;
        endcase
    end

endmodule

// File: rtl/sdram_apb_arb.sv
// Two-requester APB arbiter driving a single SDRAM APB slave port.
//   clock, reset          : single clock, asynchronous active-high reset
//   m0_* / m1_*           : upstream APB requester ports (psel marks a request)
//   out_*                 : downstream APB master port towards the SDRAM slave
//   grant_o               : one-hot owner of the current transfer, 0 while idle
// Each transfer runs IDLE -> SETUP -> ACCESS (until out_pready) -> IDLE, so the
// grant is only decided in IDLE and stays frozen for the whole transfer.
module sdram_apb_arb
    import sdram_arb_pkg::*;
#(
    parameter int unsigned PRIO_MODE = 0,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clock,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_paddr,
    input  logic              m0_psel,
    input  logic              m0_penable,
    input  logic              m0_pwrite,
    input  logic [2:0]        m0_pprot,
    input  logic [31:0]       m0_pwdata,
    input  logic [3:0]        m0_pstrb,
    output logic              m0_pready,
    output logic              m0_pslverr,
    output logic [31:0]       m0_prdata,

    input  logic [ADDR_W-1:0] m1_paddr,
    input  logic              m1_psel,
    input  logic              m1_penable,
    input  logic              m1_pwrite,
    input  logic [2:0]        m1_pprot,
    input  logic [31:0]       m1_pwdata,
    input  logic [3:0]        m1_pstrb,
    output logic              m1_pready,
    output logic              m1_pslverr,
    output logic [31:0]       m1_prdata,

    output logic [ADDR_W-1:0] out_paddr,
    output logic              out_psel,
    output logic              out_penable,
    output logic [2:0]        out_pprot,
    output logic              out_pwrite,
    output logic [31:0]       out_pwdata,
    output logic [3:0]        out_pstrb,
    input  logic              out_pready,
    input  logic              out_pslverr,
    input  logic [31:0]       out_prdata,

    output logic [1:0]        grant_o
);

    arb_state_t  state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_q, last_d;     // 1 = m1 was granted most recently
    logic [1:0]  req;
    logic [1:0]  arb_grant;
    logic        m0_active, m1_active;

    // The arbiter keys purely off psel; penable is an upstream protocol detail.
    logic unused_penable;
    assign unused_penable = m0_penable ^ m1_penable;

    assign req = {m1_psel, m0_psel};

    rr_arb2 u_rr_arb2 (
        .req   (req),
        .last  (last_q),
        .mode  (PRIO_MODE == PRIO_FIXED),
        .grant (arb_grant)
    );

    // State, grant and last-grant registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            grant_q <= GRANT_NONE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic: arbitration happens only in idle.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    grant_d = arb_grant;
                    last_d  = arb_grant[1];
                    state_d = StSetup;
                end
            end
            StSetup: begin
                state_d = StAccess;
            end
            StAccess: begin
                if (out_pready) begin
                    state_d = StIdle;
                    grant_d = GRANT_NONE;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = GRANT_NONE;
            end
        endcase
    end

    assign out_psel    = (state_q == StSetup) || (state_q == StAccess);
    assign out_penable = (state_q == StAccess);
    assign grant_o     = grant_q;

    // Downstream request mux; grant_q is all-zero in idle so every field reads 0.
    always_comb begin
        out_paddr  = '0;
        out_pprot  = 3'b000;
        out_pwrite = 1'b0;
        out_pwdata = 32'h0;
        out_pstrb  = 4'b0000;
        unique case (grant_q)
            GRANT_M0: begin
                out_paddr  = m0_paddr;
                out_pprot  = m0_pprot;
                out_pwrite = m0_pwrite;
                out_pwdata = m0_pwdata;
                out_pstrb  = m0_pstrb;
            end
            GRANT_M1: begin
                out_paddr  = m1_paddr;
                out_pprot  = m1_pprot;
                out_pwrite = m1_pwrite;
                out_pwdata = m1_pwdata;
                out_pstrb  = m1_pstrb;
            end
            default: begin
                out_paddr  = '0;
                out_pprot  = 3'b000;
                out_pwrite = 1'b0;
                out_pwdata = 32'h0;
                out_pstrb  = 4'b0000;
            end
        endcase
    end

    // Response routing. A granted port that has dropped psel mid-transfer sees
    // nothing: the downstream transfer still finishes, its response is dropped.
    assign m0_active = (state_q == StAccess) && grant_q[0] && m0_psel;
    assign m1_active = (state_q == StAccess) && grant_q[1] && m1_psel;

    assign m0_pready  = m0_active & out_pready;
    assign m0_pslverr = m0_active & out_pslverr;
    assign m0_prdata  = m0_active ? out_prdata : 32'h0;

    assign m1_pready  = m1_active & out_pready;
    assign m1_pslverr = m1_active & out_pslverr;
    assign m1_prdata  = m1_active ? out_prdata : 32'h0;

endmodule
